// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the IF/MEM SRAM access arbiter.
//   state_t : arbiter FSM states (IDLE, MEM_ACC, IF_ACC, DONE)
//   gnt_t   : which requester currently owns the SRAM (none, IF, MEM)
//   DEF_SRAM_LATENCY : default number of cycles an access holds the SRAM bus
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_SRAM_LATENCY = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEM_ACC = 2'd1,
        ST_IF_ACC  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_MEM  = 2'd2
    } gnt_t;

endpackage : mem_arb_pkg

// File: rtl/mem_wait_counter.sv
// -----------------------------------------------------------------------------
// mem_wait_counter
// Wait-state counter that times one SRAM access.
//   clk     : clock
//   rst     : synchronous active-high reset, counter -> 0
//   clr_i   : synchronous clear, counter -> 0 (has priority over inc_i)
//   inc_i   : advance the counter by one
//   tc_o    : terminal count, high while the counter equals LATENCY-1
// -----------------------------------------------------------------------------
module mem_wait_counter #(
    parameter int LATENCY = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    // One extra bit so the counter can step past LATENCY-1 on the terminal
    // cycle without wrapping before it is cleared.
    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(LATENCY - 1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule : mem_wait_counter

// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
// Shares one single-port fixed-latency SRAM between the IF stage (fetch) and
// the MEM stage (load/store). MEM always wins; each access occupies the SRAM
// for SRAM_LATENCY cycles followed by one DONE cycle carrying a ready pulse.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   if_req / if_addr             : fetch request (held until if_ready), PC
//   if_rdata / if_ready          : fetched word, one-cycle completion pulse
//   if_freeze                    : stall IF (also forced by mem_freeze)
//   mem_rd_en / mem_wr_en        : load / store request (both high = store)
//   mem_addr / mem_wdata         : load/store address, store data
//   mem_rdata / mem_ready        : load data, one-cycle completion pulse
//   mem_freeze                   : stall the whole pipeline
//   sram_en/we/addr/wdata/rdata  : SRAM bus; rdata valid in last wait cycle
//
// Optional build macro MEM_ARB_FETCH_BUF_EN: one-entry fetch buffer. A fetch
// that hits the buffer completes in one cycle without touching the SRAM; any
// store invalidates the buffer.
// -----------------------------------------------------------------------------
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int SRAM_LATENCY = DEF_SRAM_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_freeze,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_freeze,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    state_t            state_q, state_d;
    gnt_t              gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
`ifdef MEM_ARB_FETCH_BUF_EN
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
`endif

    logic mem_req;
    logic in_access;
    logic cnt_tc;

    assign mem_req   = mem_rd_en | mem_wr_en;
    assign in_access = (state_q == ST_MEM_ACC) || (state_q == ST_IF_ACC);

    // Counter runs only during an access and is held at zero otherwise, so
    // every access starts counting from 0.
    mem_wait_counter #(
        .LATENCY (SRAM_LATENCY)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (~in_access),
        .inc_i (in_access),
        .tc_o  (cnt_tc)
    );

    // NOTE: every variable assigned here gets a hold-value default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
`ifdef MEM_ARB_FETCH_BUF_EN
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    // MEM holds the older instruction, so it always goes first.
                    state_d = ST_MEM_ACC;
                    gnt_d   = GNT_MEM;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    we_d    = mem_wr_en;
`ifdef MEM_ARB_FETCH_BUF_EN
                    // Any store may alias the buffered word; drop it outright.
                    if (mem_wr_en) begin
                        buf_valid_d = 1'b0;
                    end
`endif
                end
`ifdef MEM_ARB_FETCH_BUF_EN
                else if (if_req && buf_valid_q && (if_addr == buf_addr_q)) begin
                    state_d    = ST_DONE;
                    gnt_d      = GNT_IF;
                    if_rdata_d = buf_data_q;
                end
`endif
                else if (if_req) begin
                    state_d = ST_IF_ACC;
                    gnt_d   = GNT_IF;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    we_d    = 1'b0;
                end
            end
            ST_MEM_ACC, ST_IF_ACC: begin
                if (cnt_tc) begin
                    state_d = ST_DONE;
                    if (gnt_q == GNT_IF) begin
                        if_rdata_d = sram_rdata;
`ifdef MEM_ARB_FETCH_BUF_EN
                        buf_valid_d = 1'b1;
                        buf_addr_d  = addr_q;
                        buf_data_d  = sram_rdata;
`endif
                    end else if (!we_q) begin
                        mem_rdata_d = sram_rdata;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
`ifdef MEM_ARB_FETCH_BUF_EN
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef MEM_ARB_FETCH_BUF_EN
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
`endif
        end
    end

    assign if_ready   = (state_q == ST_DONE) && (gnt_q == GNT_IF);
    assign mem_ready  = (state_q == ST_DONE) && (gnt_q == GNT_MEM);
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;

    assign sram_en    = in_access;
    assign sram_we    = (state_q == ST_MEM_ACC) && we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    // A frozen pipeline cannot let IF advance either.
    assign mem_freeze = mem_req & ~mem_ready;
    assign if_freeze  = (if_req & ~if_ready) | mem_freeze;

endmodule : mem_access_arbiter
